io_channel_fifo: RTL and testbench
==================================

IO_CHANNEL_FIFO -- requirements
Module: io_channel_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the data width of both the input and output channels.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the entries per FIFO; it is a power of two and at least 2.
REQ-003 The block SHALL have derived parameter CNT_W = log2(DEPTH)+1, meaning the width of the occupancy counters.
REQ-004 The block SHALL have port g_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port g_clr, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port input_bus, input, DATA_W bits: input device data.
REQ-007 The block SHALL have port in_dev_hs, input, 1 bit: input device request.
REQ-008 The block SHALL have port in_dev_ack, output, 1 bit: input device acknowledge.
REQ-009 The block SHALL have port output_bus, output, DATA_W bits: output device data.
REQ-010 The block SHALL have port out_dev_hs, output, 1 bit: output device request.
REQ-011 The block SHALL have port out_dev_ack, input, 1 bit: output device acknowledge.
REQ-012 The block SHALL have port cpu_rd, input, 1 bit: processor pop request for the input FIFO.
REQ-013 The block SHALL have port cpu_rd_data, output, DATA_W bits: popped word, registered.
REQ-014 The block SHALL have port cpu_rd_valid, output, 1 bit: one-cycle strobe qualifying cpu_rd_data.
REQ-015 The block SHALL have port cpu_wr, input, 1 bit: processor push request for the output FIFO.
REQ-016 The block SHALL have port cpu_wr_data, input, DATA_W bits: word pushed by cpu_wr.
REQ-017 The block SHALL have ports in_count and out_count, each output, CNT_W bits: FIFO occupancies, 0..DEPTH.
REQ-018 The block SHALL have port err, output, 2 bits, sticky: bit0 = read underflow, bit1 = write overflow.
REQ-019 The block SHALL have port err_clr, input, 1 bit: clears err.

Function
REQ-020 The input FSM SHALL have states IN_IDLE and IN_ACK; in IN_IDLE with in_dev_hs=1 and in_count<DEPTH, it SHALL push input_bus, set in_dev_ack=1 next cycle and enter IN_ACK.
REQ-021 In IN_ACK, the input FSM SHALL hold in_dev_ack=1 until in_dev_hs=0, then clear in_dev_ack the following cycle and return to IN_IDLE (4-phase, exactly one push per handshake).
REQ-022 In IN_IDLE with in_dev_hs=1 and the input FIFO full, the input FSM SHALL withhold ack with no push and no error (backpressure), and proceed one cycle after space appears.
REQ-023 The block SHALL treat cpu_rd with in_count>0 as a pop: head word on cpu_rd_data and cpu_rd_valid=1 the next cycle (latency 1); cpu_rd_valid is 0 otherwise, and cpu_rd_data holds its last value.
REQ-024 The block SHALL NOT pop on cpu_rd with in_count=0; in that case cpu_rd_valid SHALL stay 0 and err[0] SHALL be set.
REQ-025 The block SHALL treat cpu_wr with out_count<DEPTH as a push of cpu_wr_data.
REQ-026 The block SHALL drop cpu_wr with out_count=DEPTH and set err[1].
REQ-027 The output FSM SHALL have states OUT_IDLE, OUT_REQ and OUT_REL.
REQ-028 In OUT_IDLE with out_count>0 and out_dev_ack=0, the output FSM SHALL drive output_bus with the head word, set out_dev_hs=1 and enter OUT_REQ.
REQ-029 In OUT_REQ, output_bus SHALL be stable; on out_dev_ack=1 the output FSM SHALL pop, clear out_dev_hs and enter OUT_REL.
REQ-030 In OUT_REL, the output FSM SHALL wait for out_dev_ack=0, then return to OUT_IDLE.
REQ-031 A simultaneous push and pop on the same FIFO SHALL both occur, leaving the count unchanged; this is legal even when the FIFO is full or empty only if the pop is valid at cycle start.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH; counters SHALL never exceed DEPTH or underflow.
REQ-033 err bits SHALL stay set until err_clr=1; if err_clr and a new error occur in the same cycle, the error bit SHALL end set.

Reset
REQ-034 With g_clr=1 at a clock edge, the block SHALL empty both FIFOs, zero pointers and counts, put both FSMs in idle, and drive in_dev_ack, out_dev_hs, cpu_rd_valid, cpu_rd_data, output_bus and err to 0.
REQ-035 Reset SHALL abort any in-progress handshake with no push or pop; a device still holding in_dev_hs=1 after reset SHALL be treated as a new request.

Verification
REQ-036 Scenario: input_bus=8'h0A with a full 4-phase handshake, then cpu_rd -> ack high 1 cycle after hs, in_count=1, then cpu_rd_valid=1 with cpu_rd_data=8'h0A and in_count=0.
REQ-037 Scenario: 5 input handshakes with DEPTH=4 and no reads -> 4 acks, in_count=4, 5th ack held low; after one cpu_rd, the 5th ack follows.
REQ-038 Scenario: cpu_wr 8'h11, 8'h22 with out_dev_ack echoing hs after 2 cycles -> output_bus shows 8'h11 then 8'h22, in order, stable while out_dev_hs=1.
REQ-039 Scenario: cpu_rd when empty, and 5 cpu_wr with output ack held 0 -> err=2'b11; err_clr -> err=0.
REQ-040 Scenario: g_clr=1 asserted in IN_ACK with out_count=2 -> next cycle all counts 0 and all handshake outputs 0.
REQ-041 Scenario: DATA_W=16, DEPTH=8 with 8 writes and 8 reads interleaved in the same cycles -> counts constant, data order preserved across the pointer wrap.

Source files
------------

// File: rtl/io_channel_fifo.sv
// Two-FIFO I/O channel: a 4-phase input device feeds a processor-popped FIFO,
// and a processor-pushed FIFO drains to a 4-phase output device.
module io_channel_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              g_clk,
  input  logic              g_clr,
  input  logic [DATA_W-1:0] input_bus,
  input  logic              in_dev_hs,
  output logic              in_dev_ack,
  output logic [DATA_W-1:0] output_bus,
  output logic              out_dev_hs,
  input  logic              out_dev_ack,
  input  logic              cpu_rd,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_rd_valid,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [CNT_W-1:0]  in_count,
  output logic [CNT_W-1:0]  out_count,
  output logic [1:0]        err,
  input  logic              err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {IN_IDLE = 1'b0, IN_ACK = 1'b1} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE = 2'b00, OUT_REQ = 2'b01, OUT_REL = 2'b10} out_state_t;

  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return cnt + CNT_W'(1);
      2'b01:   return cnt - CNT_W'(1);
      default: return cnt;
    endcase
  endfunction

  logic [DATA_W-1:0] in_mem_r  [DEPTH];
  logic [DATA_W-1:0] out_mem_r [DEPTH];
  logic [PTR_W-1:0]  in_wptr_r, in_rptr_r, out_wptr_r, out_rptr_r;
  logic [CNT_W-1:0]  in_count_r, out_count_r;
  in_state_t         in_state_r, in_state_nxt_s;
  out_state_t        out_state_r, out_state_nxt_s;
  logic              in_dev_ack_r, out_dev_hs_r, cpu_rd_valid_r;
  logic [DATA_W-1:0] cpu_rd_data_r, output_bus_r;
  logic [1:0]        err_r;
  logic              in_push_s, in_pop_s, in_room_s, rd_underflow_s;
  logic              out_push_s, out_pop_s, out_load_s, wr_overflow_s;

  // A pop valid at cycle start frees a slot for a push in the same cycle.
  assign in_pop_s       = cpu_rd && (in_count_r != '0);
  assign rd_underflow_s = cpu_rd && (in_count_r == '0);
  assign in_room_s      = (in_count_r != FULL_CNT) || in_pop_s;
  assign out_push_s     = cpu_wr && ((out_count_r != FULL_CNT) || out_pop_s);
  assign wr_overflow_s  = cpu_wr && !out_push_s;

  // Input device handshake: next state and push decision
  always_comb begin
    in_state_nxt_s = in_state_r;
    in_push_s      = 1'b0;
    case (in_state_r)
      IN_IDLE: begin
        if (in_dev_hs && in_room_s) begin
          in_push_s      = 1'b1;
          in_state_nxt_s = IN_ACK;
        end else begin
          in_state_nxt_s = IN_IDLE;
        end
      end
      IN_ACK: begin
        if (!in_dev_hs) begin
          in_state_nxt_s = IN_IDLE;
        end else begin
          in_state_nxt_s = IN_ACK;
        end
      end
      default: in_state_nxt_s = IN_IDLE;
    endcase
  end

  // Output device handshake: next state, head load and pop decision
  always_comb begin
    out_state_nxt_s = out_state_r;
    out_load_s      = 1'b0;
    out_pop_s       = 1'b0;
    case (out_state_r)
      OUT_IDLE: begin
        if ((out_count_r != '0) && !out_dev_ack) begin
          out_load_s      = 1'b1;
          out_state_nxt_s = OUT_REQ;
        end else begin
          out_state_nxt_s = OUT_IDLE;
        end
      end
      OUT_REQ: begin
        if (out_dev_ack) begin
          out_pop_s       = 1'b1;
          out_state_nxt_s = OUT_REL;
        end else begin
          out_state_nxt_s = OUT_REQ;
        end
      end
      OUT_REL: begin
        if (!out_dev_ack) begin
          out_state_nxt_s = OUT_IDLE;
        end else begin
          out_state_nxt_s = OUT_REL;
        end
      end
      default: out_state_nxt_s = OUT_IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care while the counts say empty
  always_ff @(posedge g_clk) begin
    if (!g_clr && in_push_s) begin
      in_mem_r[in_wptr_r] <= input_bus;
    end
    if (!g_clr && out_push_s) begin
      out_mem_r[out_wptr_r] <= cpu_wr_data;
    end
  end

  // Input side state, pointers, count and processor read port
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      in_state_r     <= IN_IDLE;
      in_dev_ack_r   <= 1'b0;
      in_wptr_r      <= '0;
      in_rptr_r      <= '0;
      in_count_r     <= '0;
      cpu_rd_valid_r <= 1'b0;
      cpu_rd_data_r  <= '0;
    end else begin
      in_state_r     <= in_state_nxt_s;
      in_dev_ack_r   <= (in_state_nxt_s == IN_ACK);
      in_count_r     <= next_count(in_count_r, in_push_s, in_pop_s);
      cpu_rd_valid_r <= in_pop_s;
      if (in_push_s) begin
        in_wptr_r <= in_wptr_r + PTR_W'(1);
      end
      if (in_pop_s) begin
        in_rptr_r     <= in_rptr_r + PTR_W'(1);
        cpu_rd_data_r <= in_mem_r[in_rptr_r];
      end
    end
  end

  // Output side state, pointers, count, device bus and sticky errors
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      out_state_r  <= OUT_IDLE;
      out_dev_hs_r <= 1'b0;
      output_bus_r <= '0;
      out_wptr_r   <= '0;
      out_rptr_r   <= '0;
      out_count_r  <= '0;
      err_r        <= 2'b00;
    end else begin
      out_state_r  <= out_state_nxt_s;
      out_dev_hs_r <= (out_state_nxt_s == OUT_REQ);
      out_count_r  <= next_count(out_count_r, out_push_s, out_pop_s);
      err_r        <= (err_r & ~{2{err_clr}}) | {wr_overflow_s, rd_underflow_s};
      if (out_load_s) begin
        output_bus_r <= out_mem_r[out_rptr_r];
      end
      if (out_push_s) begin
        out_wptr_r <= out_wptr_r + PTR_W'(1);
      end
      if (out_pop_s) begin
        out_rptr_r <= out_rptr_r + PTR_W'(1);
      end
    end
  end

  assign in_dev_ack   = in_dev_ack_r;
  assign out_dev_hs   = out_dev_hs_r;
  assign output_bus   = output_bus_r;
  assign cpu_rd_valid = cpu_rd_valid_r;
  assign cpu_rd_data  = cpu_rd_data_r;
  assign in_count     = in_count_r;
  assign out_count    = out_count_r;
  assign err          = err_r;

endmodule

// File: tb/tb_io_channel_fifo.sv
// Directed bench for io_channel_fifo: default 8-bit/4-deep instance plus a
// 16-bit/8-deep instance for the pointer-wrap scenario.
module tb_io_channel_fifo;

  logic        clk = 1'b0;
  logic        g_clr = 1'b1;
  logic [7:0]  input_bus = 8'h00;
  logic        in_dev_hs = 1'b0;
  logic        in_dev_ack;
  logic [7:0]  output_bus;
  logic        out_dev_hs;
  logic        out_dev_ack = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_rd_data;
  logic        cpu_rd_valid;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_wr_data = 8'h00;
  logic [2:0]  in_count, out_count;
  logic [1:0]  err;
  logic        err_clr = 1'b0;

  logic [15:0] input_bus16 = 16'h0000;
  logic        hs16 = 1'b0;
  logic        ack16;
  logic [15:0] output_bus16;
  logic        out_hs16;
  logic        cpu_rd16 = 1'b0;
  logic [15:0] rd_data16;
  logic        rd_valid16;
  logic [3:0]  in_count16, out_count16;
  logic [1:0]  err16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  io_channel_fifo u_dut (
    .g_clk(clk), .g_clr(g_clr), .input_bus(input_bus), .in_dev_hs(in_dev_hs),
    .in_dev_ack(in_dev_ack), .output_bus(output_bus), .out_dev_hs(out_dev_hs),
    .out_dev_ack(out_dev_ack), .cpu_rd(cpu_rd), .cpu_rd_data(cpu_rd_data),
    .cpu_rd_valid(cpu_rd_valid), .cpu_wr(cpu_wr), .cpu_wr_data(cpu_wr_data),
    .in_count(in_count), .out_count(out_count), .err(err), .err_clr(err_clr)
  );

  io_channel_fifo #(.DATA_W(16), .DEPTH(8)) u_dut16 (
    .g_clk(clk), .g_clr(g_clr), .input_bus(input_bus16), .in_dev_hs(hs16),
    .in_dev_ack(ack16), .output_bus(output_bus16), .out_dev_hs(out_hs16),
    .out_dev_ack(1'b0), .cpu_rd(cpu_rd16), .cpu_rd_data(rd_data16),
    .cpu_rd_valid(rd_valid16), .cpu_wr(1'b0), .cpu_wr_data(16'h0000),
    .in_count(in_count16), .out_count(out_count16), .err(err16), .err_clr(1'b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic in_hs(input logic [7:0] d);
    int i;
    input_bus = d;
    in_dev_hs = 1'b1;
    i = 0;
    while (!in_dev_ack && i < 10) begin tick(); i++; end
    check("in_ack_rise", {31'd0, in_dev_ack}, 32'd1);
    in_dev_hs = 1'b0;
    i = 0;
    while (in_dev_ack && i < 10) begin tick(); i++; end
    check("in_ack_fall", {31'd0, in_dev_ack}, 32'd0);
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] exp);
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    check({tag, "_valid"}, {31'd0, cpu_rd_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, cpu_rd_data}, {24'd0, exp});
  endtask

  task automatic out_accept(input string tag, input logic [7:0] exp);
    int i;
    i = 0;
    while (!out_dev_hs && i < 10) begin tick(); i++; end
    check({tag, "_hs"}, {31'd0, out_dev_hs}, 32'd1);
    check({tag, "_bus"}, {24'd0, output_bus}, {24'd0, exp});
    tick();
    tick();
    check({tag, "_bus_stable"}, {23'd0, out_dev_hs, output_bus}, {23'd0, 1'b1, exp});
    out_dev_ack = 1'b1;
    tick();
    check({tag, "_hs_drop"}, {31'd0, out_dev_hs}, 32'd0);
    out_dev_ack = 1'b0;
    tick();
  endtask

  task automatic in_hs16(input logic [15:0] d, input logic rd, input logic [15:0] exp_rd,
                         input logic [3:0] exp_cnt);
    input_bus16 = d;
    hs16 = 1'b1;
    cpu_rd16 = rd;
    tick();
    cpu_rd16 = 1'b0;
    check("w16_ack", {31'd0, ack16}, 32'd1);
    check("w16_count", {28'd0, in_count16}, {28'd0, exp_cnt});
    if (rd) begin
      check("w16_rd_data", {15'd0, rd_valid16, rd_data16}, {15'd0, 1'b1, exp_rd});
    end
    hs16 = 1'b0;
    tick();
    check("w16_ack_fall", {31'd0, ack16}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    g_clr = 1'b0;
    check("rst_in_count", {29'd0, in_count}, 32'd0);
    check("rst_out_count", {29'd0, out_count}, 32'd0);
    check("rst_hs_ack", {30'd0, in_dev_ack, out_dev_hs}, 32'd0);
    check("rst_rd", {23'd0, cpu_rd_valid, cpu_rd_data}, 32'd0);
    check("rst_bus_err", {22'd0, err, output_bus}, 32'd0);

    // single input handshake then processor read
    input_bus = 8'h0A;
    in_dev_hs = 1'b1;
    tick();
    check("s1_ack", {31'd0, in_dev_ack}, 32'd1);
    check("s1_count", {29'd0, in_count}, 32'd1);
    in_dev_hs = 1'b0;
    tick();
    check("s1_ack_fall", {31'd0, in_dev_ack}, 32'd0);
    cpu_read("s1_rd", 8'h0A);
    check("s1_count_after", {29'd0, in_count}, 32'd0);
    tick();
    check("s1_valid_pulse", {31'd0, cpu_rd_valid}, 32'd0);
    check("s1_data_hold", {24'd0, cpu_rd_data}, 32'h0A);

    // backpressure on a full input FIFO
    in_hs(8'h01);
    in_hs(8'h02);
    in_hs(8'h03);
    in_hs(8'h04);
    check("bp_full_count", {29'd0, in_count}, 32'd4);
    input_bus = 8'h55;
    in_dev_hs = 1'b1;
    tick();
    tick();
    tick();
    check("bp_ack_held", {31'd0, in_dev_ack}, 32'd0);
    check("bp_count", {29'd0, in_count}, 32'd4);
    check("bp_no_err", {30'd0, err}, 32'd0);
    cpu_read("bp_rd", 8'h01);
    for (int i = 0; i < 5 && !in_dev_ack; i++) tick();
    check("bp_fifth_ack", {31'd0, in_dev_ack}, 32'd1);
    check("bp_count_refill", {29'd0, in_count}, 32'd4);
    in_dev_hs = 1'b0;
    tick();
    tick();
    cpu_read("bp_d2", 8'h02);
    cpu_read("bp_d3", 8'h03);
    cpu_read("bp_d4", 8'h04);
    cpu_read("bp_d5", 8'h55);
    check("bp_empty", {29'd0, in_count}, 32'd0);

    // ordered output handshakes
    cpu_wr = 1'b1;
    cpu_wr_data = 8'h11;
    tick();
    cpu_wr_data = 8'h22;
    tick();
    cpu_wr = 1'b0;
    check("out_count2", {29'd0, out_count}, 32'd2);
    out_accept("out_w1", 8'h11);
    out_accept("out_w2", 8'h22);
    check("out_empty", {29'd0, out_count}, 32'd0);
    tick();
    check("out_idle_hs", {31'd0, out_dev_hs}, 32'd0);

    // underflow, overflow and error clear
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    check("uf_no_valid", {31'd0, cpu_rd_valid}, 32'd0);
    check("uf_err", {30'd0, err}, 32'd1);
    cpu_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_wr_data = 8'hE0 + 8'(i);
      tick();
    end
    cpu_wr = 1'b0;
    check("of_count", {29'd0, out_count}, 32'd4);
    check("of_err", {30'd0, err}, 32'd3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", {30'd0, err}, 32'd0);
    err_clr = 1'b1;
    cpu_rd = 1'b1;
    tick();
    err_clr = 1'b0;
    cpu_rd = 1'b0;
    check("err_clr_vs_new", {30'd0, err}, 32'd1);

    // reset in the middle of handshakes
    g_clr = 1'b1;
    tick();
    g_clr = 1'b0;
    cpu_wr = 1'b1;
    cpu_wr_data = 8'hAA;
    tick();
    cpu_wr_data = 8'hBB;
    tick();
    cpu_wr = 1'b0;
    input_bus = 8'h77;
    in_dev_hs = 1'b1;
    tick();
    check("mid_ack", {31'd0, in_dev_ack}, 32'd1);
    check("mid_out_count", {29'd0, out_count}, 32'd2);
    check("mid_out_hs", {31'd0, out_dev_hs}, 32'd1);
    g_clr = 1'b1;
    tick();
    check("clr_counts", {26'd0, in_count, out_count}, 32'd0);
    check("clr_hs_ack", {30'd0, in_dev_ack, out_dev_hs}, 32'd0);
    check("clr_bus_err", {22'd0, err, output_bus}, 32'd0);
    check("clr_rd", {23'd0, cpu_rd_valid, cpu_rd_data}, 32'd0);
    g_clr = 1'b0;
    tick();
    check("clr_new_req_ack", {31'd0, in_dev_ack}, 32'd1);
    check("clr_new_req_count", {29'd0, in_count}, 32'd1);
    in_dev_hs = 1'b0;
    tick();
    tick();

    // wide/deep instance: prefill 3, then push and pop on the same edge across the wrap
    for (int i = 0; i < 3; i++) begin
      in_hs16(16'h1000 + 16'(i), 1'b0, 16'h0000, 4'(i + 1));
    end
    for (int i = 0; i < 8; i++) begin
      in_hs16(16'hA000 + 16'(i), 1'b1,
              (i < 3) ? 16'h1000 + 16'(i) : 16'hA000 + 16'(i - 3), 4'd3);
    end
    for (int i = 0; i < 3; i++) begin
      cpu_rd16 = 1'b1;
      tick();
      cpu_rd16 = 1'b0;
      check("w16_drain", {15'd0, rd_valid16, rd_data16}, {15'd0, 1'b1, 16'hA005 + 16'(i)});
    end
    check("w16_empty", {28'd0, in_count16}, 32'd0);
    check("w16_no_err", {30'd0, err16}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
